// File: rtl/camera_capture_pkg.sv
// Shared types for the DVP camera capture path: FSM states,
// coordinate width and RGB565 pixel layout.
package camera_capture_pkg;

    localparam int COORD_W = 16;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t COORD_MAX = '1;

    typedef enum logic [1:0] {
        ST_SKIP   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic coord_t sat_inc(input coord_t v);
        return (v == COORD_MAX) ? v : v + coord_t'(1);
    endfunction

endpackage

// File: rtl/dvp_byte_pair.sv
// Pairs consecutive DVP bytes (high byte first) into one
// registered 16-bit word; reports line end and odd byte counts.
module dvp_byte_pair
    import camera_capture_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       clear_i,
    input  logic       href_i,
    input  logic       href_prev_i,
    input  logic [7:0] data_i,
    output logic       pair_o,
    output logic       eol_o,
    output logic       odd_o,
    output rgb565_t    word_o,
    output logic       vld_o
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;
    rgb565_t    word_q, word_d;
    logic       vld_q, vld_d;

    assign eol_o  = en_i && href_prev_i && !href_i;
    assign pair_o = en_i && href_i && phase_q;
    assign odd_o  = eol_o && phase_q;
    assign word_o = word_q;
    assign vld_o  = vld_q;

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        word_d  = word_q;
        vld_d   = 1'b0;
        if (clear_i || eol_o) begin
            phase_d = 1'b0;
        end else if (en_i && href_i) begin
            phase_d = !phase_q;
            if (phase_q) begin
                word_d = rgb565_t'({hi_q, data_i});
                vld_d  = 1'b1;
            end else begin
                hi_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: rtl/camera_dvp_capture.sv
// DVP byte stream to cropped RGB565 pixel stream, with start-up
// frame skipping and sticky line/frame geometry error flags.
module camera_dvp_capture
    import camera_capture_pkg::*;
#(
    parameter logic [15:0] IMAGE_SIZE_H = 16'd256,
    parameter logic [15:0] IMAGE_SIZE_V = 16'd384,
    parameter logic [7:0]  FRAME_SKIP   = 8'd10,
    parameter logic        VSYNC_POL    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cam_vsync,
    input  logic        i_cam_href,
    input  logic [7:0]  i_cam_data,
    output logic        o_rgb565_vde,
    output logic        o_rgb565_vsync,
    output logic [15:0] o_rgb565_data,
    output logic        o_frame_done,
    output logic        o_line_err,
    output logic        o_frame_err
);

    logic       s1_vsync_q, s1_href_q;
    logic [7:0] s1_data_q;
    logic       s2_vsync_q, s2_href_q;
    logic [1:0] fill_q;

    cap_state_e  state_q, state_d;
    logic [7:0]  skip_q, skip_d;
    coord_t      x_q, x_d;
    coord_t      y_q, y_d;
    logic        keep_q, keep_d;
    logic        vde_q, vde_d;
    logic [15:0] data_q, data_d;
    logic        vsync_q, vsync_d;
    logic        done_q, done_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;

    logic    frame_start, frame_end, en;
    logic    pair, eol, odd, pix_vld;
    rgb565_t pix_word;

    // Edges are only trusted once both sync stages hold sensor data.
    assign frame_start = fill_q[1] && (s1_vsync_q != VSYNC_POL)
                                   && (s2_vsync_q == VSYNC_POL);
    assign frame_end   = fill_q[1] && (s1_vsync_q == VSYNC_POL)
                                   && (s2_vsync_q != VSYNC_POL);
    assign en          = (state_q == ST_ACTIVE)
                      && (s1_vsync_q != VSYNC_POL);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vsync_q <= 1'b0;
            s1_href_q  <= 1'b0;
            s1_data_q  <= '0;
            s2_vsync_q <= 1'b0;
            s2_href_q  <= 1'b0;
            fill_q     <= '0;
        end else begin
            s1_vsync_q <= i_cam_vsync;
            s1_href_q  <= i_cam_href;
            s1_data_q  <= i_cam_data;
            s2_vsync_q <= s1_vsync_q;
            s2_href_q  <= s1_href_q;
            fill_q     <= {fill_q[0], 1'b1};
        end
    end

    dvp_byte_pair u_pair (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .en_i        (en),
        .clear_i     (frame_start),
        .href_i      (s1_href_q),
        .href_prev_i (s2_href_q),
        .data_i      (s1_data_q),
        .pair_o      (pair),
        .eol_o       (eol),
        .odd_o       (odd),
        .word_o      (pix_word),
        .vld_o       (pix_vld)
    );

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        x_d         = x_q;
        y_d         = y_q;
        keep_d      = 1'b0;
        vde_d       = 1'b0;
        data_d      = data_q;
        vsync_d     = vsync_q;
        done_d      = 1'b0;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;

        if (pix_vld && keep_q) begin
            vde_d  = 1'b1;
            data_d = pix_word;
        end

        if (pair) begin
            keep_d = (x_q < IMAGE_SIZE_H) && (y_q < IMAGE_SIZE_V);
            x_d    = sat_inc(x_q);
        end

        if (eol) begin
            x_d = '0;
            y_d = sat_inc(y_q);
            if (odd || ((y_q < IMAGE_SIZE_V) && (x_q < IMAGE_SIZE_H)))
                line_err_d = 1'b1;
        end

        unique case (state_q)
            ST_SKIP: begin
                if (skip_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else if (frame_end) begin
                    skip_d = skip_q - 8'd1;
                    if (skip_q == 8'd1)
                        state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Frame ends here are mid-frame entries and are ignored.
                if (frame_start) begin
                    state_d     = ST_ACTIVE;
                    x_d         = '0;
                    y_d         = '0;
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                    vsync_d     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (frame_end) begin
                    state_d = ST_IDLE;
                    vsync_d = 1'b0;
                    done_d  = 1'b1;
                    if (y_q < IMAGE_SIZE_V)
                        frame_err_d = 1'b1;
                end
            end
            default: state_d = ST_SKIP;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_SKIP;
            skip_q      <= FRAME_SKIP;
            x_q         <= '0;
            y_q         <= '0;
            keep_q      <= 1'b0;
            vde_q       <= 1'b0;
            data_q      <= '0;
            vsync_q     <= 1'b0;
            done_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            x_q         <= x_d;
            y_q         <= y_d;
            keep_q      <= keep_d;
            vde_q       <= vde_d;
            data_q      <= data_d;
            vsync_q     <= vsync_d;
            done_q      <= done_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_rgb565_vde   = vde_q;
    assign o_rgb565_vsync = vsync_q;
    assign o_rgb565_data  = data_q;
    assign o_frame_done   = done_q;
    assign o_line_err     = line_err_q;
    assign o_frame_err    = frame_err_q;

endmodule
